// File: rtl/nn_config_pkg.sv
// -----------------------------------------------------------------------------
// nn_config_pkg
// Shared NPU configuration: network geometry, fixed-point format and the
// types used by the runtime weight/bias loader (opcodes, error codes,
// loader FSM states, command-header field positions).
// -----------------------------------------------------------------------------
package nn_config_pkg;

    // Fixed-point weight/bias format
    localparam int NN_DATA_WIDTH    = 16;
    localparam int WEIGHT_INT_WIDTH = 4;

    // Network geometry
    localparam int NN_NUM_LAYERS  = 5;
    localparam int INPUT_SIZE     = 784;
    localparam int L1_NEURONS     = 30;
    localparam int L2_NEURONS     = 30;
    localparam int L3_NEURONS     = 10;
    localparam int L4_NEURONS     = 10;
    localparam int L5_NEURONS     = 10;
    localparam int NN_MAX_NEURONS = 32;
    localparam int NN_MAX_WEIGHTS = 1024;

    // Neurons per layer and weights per neuron (index 0 = layer 1).
    // A neuron has one weight per output of the previous layer.
    localparam int LAYER_NEURONS_DEF [NN_NUM_LAYERS] =
        '{L1_NEURONS, L2_NEURONS, L3_NEURONS, L4_NEURONS, L5_NEURONS};
    localparam int LAYER_WEIGHTS_DEF [NN_NUM_LAYERS] =
        '{INPUT_SIZE, L1_NEURONS, L2_NEURONS, L3_NEURONS, L4_NEURONS};

    // Command header layout: [31:28] opcode, [27:24] layer, [23:16] neuron,
    // [15:0] payload word count
    localparam int HDR_OP_MSB     = 31;
    localparam int HDR_OP_LSB     = 28;
    localparam int HDR_LAYER_MSB  = 27;
    localparam int HDR_LAYER_LSB  = 24;
    localparam int HDR_NEURON_MSB = 23;
    localparam int HDR_NEURON_LSB = 16;
    localparam int HDR_COUNT_MSB  = 15;
    localparam int HDR_COUNT_LSB  = 0;

    typedef enum logic [3:0] {
        OP_WEIGHT = 4'd1,
        OP_BIAS   = 4'd2
    } loader_op_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_COUNT  = 2'd2,
        ERR_OPCODE = 2'd3
    } loader_err_e;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_DRAIN = 2'd2
    } loader_state_e;

    // Sticky error update: the first error recorded wins.
    function automatic loader_err_e sticky_err(input loader_err_e cur,
                                               input loader_err_e hit);
        return (cur == ERR_NONE) ? hit : cur;
    endfunction

endpackage

// File: rtl/nn_load_tracker.sv
// -----------------------------------------------------------------------------
// nn_load_tracker
// Per-neuron load bookkeeping for the weight loader. Each real neuron owns a
// weights-loaded bit and a bias-loaded bit; all_loaded_o is the registered
// AND over every real neuron. Slots at or beyond a layer's neuron count are
// never built and read as "loaded" in the reduction.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear_i       synchronous clear of all bits and of all_loaded_o
//   set_w_i       mark weights of (layer_i, neuron_i) as loaded
//   set_b_i       mark bias of (layer_i, neuron_i) as loaded
//   layer_i       target layer, 1-based
//   neuron_i      target neuron within the layer
//   all_loaded_o  every real neuron has weights and bias loaded
// -----------------------------------------------------------------------------
module nn_load_tracker
    import nn_config_pkg::*;
#(
    parameter int NUM_LAYERS                 = NN_NUM_LAYERS,
    parameter int MAX_NEURONS                = NN_MAX_NEURONS,
    parameter int LAYER_NEURONS [NUM_LAYERS] = LAYER_NEURONS_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic                             set_w_i,
    input  logic                             set_b_i,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]  layer_i,
    input  logic [$clog2(MAX_NEURONS)-1:0]   neuron_i,
    output logic                             all_loaded_o
);
    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam int NW = $clog2(MAX_NEURONS);

    logic [NUM_LAYERS-1:0] layer_done;
    logic                  all_loaded_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            logic [MAX_NEURONS-1:0] neuron_done;

            for (gj = 0; gj < MAX_NEURONS; gj++) begin : g_neuron
                if (gj < LAYER_NEURONS[gi]) begin : g_real
                    logic w_q;
                    logic b_q;
                    logic hit;

                    assign hit = (layer_i == LW'(gi + 1)) && (neuron_i == NW'(gj));

                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            w_q <= 1'b0;
                            b_q <= 1'b0;
                        end else if (clear_i) begin
                            w_q <= 1'b0;
                            b_q <= 1'b0;
                        end else begin
                            // Reloads leave an already-set bit set
                            if (set_w_i && hit) w_q <= 1'b1;
                            if (set_b_i && hit) b_q <= 1'b1;
                        end
                    end

                    assign neuron_done[gj] = w_q & b_q;
                end else begin : g_unused
                    assign neuron_done[gj] = 1'b1;
                end
            end

            assign layer_done[gi] = &neuron_done;
        end
    endgenerate

    // Registered reduction: rises the cycle after the bit that completes
    // the model is set, i.e. one cycle after the final write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_loaded_q <= 1'b0;
        end else if (clear_i) begin
            all_loaded_q <= 1'b0;
        end else begin
            all_loaded_q <= &layer_done;
        end
    end

    assign all_loaded_o = all_loaded_q;

endmodule

// File: rtl/nn_weight_loader.sv
// -----------------------------------------------------------------------------
// nn_weight_loader
// Runtime weight/bias loader. Consumes a 32-bit valid/ready command stream of
// headers (opcode/layer/neuron/count) each followed by `count` payload words,
// validates each header against the layer geometry, issues one registered
// write per payload word and tracks which neurons are fully loaded.
// With PRETRAINED=1 the loader is inert: never ready, no writes, all_loaded=1.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous: clears load bitmap and err, FSM back to idle
//   in_valid     command word valid
//   in_ready     loader accepts a word (always 1 after reset, unless PRETRAINED)
//   in_data      header or payload word
//   wr_en        weight memory write strobe (1-cycle pulse)
//   bias_wr_en   bias register write strobe (1-cycle pulse)
//   wr_layer     target layer, 1-based
//   wr_neuron    target neuron
//   wr_addr      weight index (0 for bias)
//   wr_data      payload word, low DATA_WIDTH bits
//   err          sticky error: 0 none, 1 bad layer/neuron, 2 bad count, 3 bad opcode
//   all_loaded   every neuron has weights and bias loaded
// -----------------------------------------------------------------------------
module nn_weight_loader
    import nn_config_pkg::*;
#(
    parameter bit PRETRAINED                 = 1'b0,
    parameter int DATA_WIDTH                 = NN_DATA_WIDTH,
    parameter int NUM_LAYERS                 = NN_NUM_LAYERS,
    parameter int MAX_NEURONS                = NN_MAX_NEURONS,
    parameter int MAX_WEIGHTS                = NN_MAX_WEIGHTS,
    parameter int LAYER_NEURONS [NUM_LAYERS] = LAYER_NEURONS_DEF,
    parameter int LAYER_WEIGHTS [NUM_LAYERS] = LAYER_WEIGHTS_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_data,
    output logic                             wr_en,
    output logic                             bias_wr_en,
    output logic [$clog2(NUM_LAYERS+1)-1:0]  wr_layer,
    output logic [$clog2(MAX_NEURONS)-1:0]   wr_neuron,
    output logic [$clog2(MAX_WEIGHTS)-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [1:0]                       err,
    output logic                             all_loaded
);
    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam int NW = $clog2(MAX_NEURONS);
    localparam int AW = $clog2(MAX_WEIGHTS);

    // ---------------------------------------------------------------- state
    loader_state_e          state_q, state_d;
    logic [15:0]            remaining_q, remaining_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [LW-1:0]          layer_q, layer_d;
    logic [NW-1:0]          neuron_q, neuron_d;
    logic                   is_bias_q, is_bias_d;
    loader_err_e            err_q, err_d;
    logic                   in_ready_q;

    logic                   wr_en_q, wr_en_d;
    logic                   bias_wr_en_q, bias_wr_en_d;
    logic [LW-1:0]          wr_layer_q, wr_layer_d;
    logic [NW-1:0]          wr_neuron_q, wr_neuron_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

    logic                   set_w;
    logic                   set_b;
    logic                   trk_all_loaded;

    // A pretrained build ignores clear so err/bitmap stay at reset values.
    logic                   clear_eff;
    logic                   beat;

    assign clear_eff = clear && !PRETRAINED;
    assign beat      = in_valid && in_ready_q;

    // --------------------------------------------------------- header decode
    logic [3:0]   hdr_op;
    logic [3:0]   hdr_layer;
    logic [7:0]   hdr_neuron;
    logic [15:0]  hdr_count;
    logic         hdr_layer_ok;
    int           hdr_neurons;
    int           hdr_weights;
    loader_err_e  hdr_err;

    assign hdr_op     = in_data[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_layer  = in_data[HDR_LAYER_MSB:HDR_LAYER_LSB];
    assign hdr_neuron = in_data[HDR_NEURON_MSB:HDR_NEURON_LSB];
    assign hdr_count  = in_data[HDR_COUNT_MSB:HDR_COUNT_LSB];

    // Look up geometry of the addressed layer; an out-of-range layer leaves
    // hdr_layer_ok low and the geometry at 0.
    always_comb begin
        hdr_layer_ok = 1'b0;
        hdr_neurons  = 0;
        hdr_weights  = 0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (int'(hdr_layer) == i + 1) begin
                hdr_layer_ok = 1'b1;
                hdr_neurons  = LAYER_NEURONS[i];
                hdr_weights  = LAYER_WEIGHTS[i];
            end
        end
    end

    // First failing check wins: opcode, then range, then count.
    always_comb begin
        hdr_err = ERR_NONE;
        if (hdr_op != OP_WEIGHT && hdr_op != OP_BIAS) begin
            hdr_err = ERR_OPCODE;
        end else if (!hdr_layer_ok || int'(hdr_neuron) >= hdr_neurons) begin
            hdr_err = ERR_RANGE;
        end else if (hdr_op == OP_WEIGHT && int'(hdr_count) != hdr_weights) begin
            hdr_err = ERR_COUNT;
        end else if (hdr_op == OP_BIAS && hdr_count != 16'd1) begin
            hdr_err = ERR_COUNT;
        end
    end

    // ------------------------------------------------------------ FSM (comb)
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        addr_d       = addr_q;
        layer_d      = layer_q;
        neuron_d     = neuron_q;
        is_bias_d    = is_bias_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        bias_wr_en_d = 1'b0;
        wr_layer_d   = wr_layer_q;
        wr_neuron_d  = wr_neuron_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        set_w        = 1'b0;
        set_b        = 1'b0;

        if (clear_eff) begin
            // Any same-cycle beat is dropped
            state_d     = LD_IDLE;
            remaining_d = 16'd0;
            err_d       = ERR_NONE;
        end else if (beat) begin
            unique case (state_q)
                LD_IDLE: begin
                    if (hdr_err == ERR_NONE) begin
                        state_d     = LD_LOAD;
                        remaining_d = hdr_count;
                        addr_d      = '0;
                        layer_d     = LW'(hdr_layer);
                        neuron_d    = NW'(hdr_neuron);
                        is_bias_d   = (hdr_op == OP_BIAS);
                    end else begin
                        err_d = sticky_err(err_q, hdr_err);
                        // A rejected header still owns its payload words
                        if (hdr_count != 16'd0) begin
                            state_d     = LD_DRAIN;
                            remaining_d = hdr_count;
                        end
                    end
                end
                LD_LOAD: begin
                    wr_en_d      = !is_bias_q;
                    bias_wr_en_d = is_bias_q;
                    wr_layer_d   = layer_q;
                    wr_neuron_d  = neuron_q;
                    wr_addr_d    = addr_q;
                    wr_data_d    = in_data[DATA_WIDTH-1:0];
                    addr_d       = addr_q + AW'(1);
                    remaining_d  = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = LD_IDLE;
                        set_w   = !is_bias_q;
                        set_b   = is_bias_q;
                    end
                end
                LD_DRAIN: begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = LD_IDLE;
                    end
                end
                default: begin
                    state_d = LD_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LD_IDLE;
            remaining_q  <= 16'd0;
            addr_q       <= '0;
            layer_q      <= '0;
            neuron_q     <= '0;
            is_bias_q    <= 1'b0;
            err_q        <= ERR_NONE;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            bias_wr_en_q <= 1'b0;
            wr_layer_q   <= '0;
            wr_neuron_q  <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            layer_q      <= layer_d;
            neuron_q     <= neuron_d;
            is_bias_q    <= is_bias_d;
            err_q        <= err_d;
            in_ready_q   <= !PRETRAINED;
            wr_en_q      <= wr_en_d;
            bias_wr_en_q <= bias_wr_en_d;
            wr_layer_q   <= wr_layer_d;
            wr_neuron_q  <= wr_neuron_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // ------------------------------------------------------- load tracking
    nn_load_tracker #(
        .NUM_LAYERS    (NUM_LAYERS),
        .MAX_NEURONS   (MAX_NEURONS),
        .LAYER_NEURONS (LAYER_NEURONS)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_eff),
        .set_w_i      (set_w),
        .set_b_i      (set_b),
        .layer_i      (layer_q),
        .neuron_i     (neuron_q),
        .all_loaded_o (trk_all_loaded)
    );

    // --------------------------------------------------------------- outputs
    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign bias_wr_en = bias_wr_en_q;
    assign wr_layer   = wr_layer_q;
    assign wr_neuron  = wr_neuron_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign err        = err_q;
    assign all_loaded = PRETRAINED ? 1'b1 : trk_all_loaded;

endmodule
